// File: rtl/dbus_demux.sv
// Data-side bus splitter: one CPU load/store port routed by address to DM (slave 0)
// or the MMIO window (slave 1), with per-request timeout and error completion.
`timescale 1ns/1ps
module dbus_demux #(
    parameter logic [31:0] DM_SIZE  = 32'h0000_3000,
    parameter logic [31:0] IO_BASE  = 32'h0000_7F00,
    parameter logic [31:0] IO_SIZE  = 32'h0000_0100,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic        s0_stb,
    output logic        s1_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_be,
    input  logic        s0_ack,
    input  logic        s1_ack,
    input  logic [31:0] s0_rdata,
    input  logic [31:0] s1_rdata
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // 33-bit window bounds so IO_BASE+IO_SIZE cannot wrap around zero
    localparam logic [32:0] DM_END = {1'b0, DM_SIZE};
    localparam logic [32:0] IO_LO  = {1'b0, IO_BASE};
    localparam logic [32:0] IO_HI  = {1'b0, IO_BASE} + {1'b0, IO_SIZE};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic          sel_reg, sel_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_reg, we_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [3:0]    be_reg, be_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          err_reg, err_next;

    logic [32:0] addr33;
    logic        hit_dm, hit_io;
    logic        slv_ack;
    logic [31:0] slv_rdata;
    logic [1:0]  stb_vec;

    // The window is decoded as the request is latched; the chosen slave is held in sel_reg
    assign addr33 = {1'b0, cpu_addr};
    assign hit_dm = (addr33 < DM_END);
    assign hit_io = (addr33 >= IO_LO) && (addr33 < IO_HI);

    assign slv_ack   = sel_reg ? s1_ack   : s0_ack;
    assign slv_rdata = sel_reg ? s1_rdata : s0_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (cpu_req) begin
                    we_next    = cpu_we;
                    addr_next  = cpu_addr;
                    wdata_next = cpu_wdata;
                    be_next    = cpu_be;
                    if (hit_dm || hit_io) begin
                        sel_next   = hit_io;
                        state_next = BUSY;
                    end else begin
                        err_next   = 1'b1;
                        rdata_next = ERR_DATA;
                        state_next = DONE;
                    end
                end
            end
            BUSY: begin
                if (slv_ack) begin
                    err_next   = 1'b0;
                    rdata_next = we_reg ? 32'h0 : slv_rdata;
                    cnt_next   = '0;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    rdata_next = ERR_DATA;
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stb
            assign stb_vec[gi] = (state_reg == BUSY) && (sel_reg == gi[0]);
        end
    endgenerate

    assign s0_stb    = stb_vec[0];
    assign s1_stb    = stb_vec[1];
    assign s_we      = we_reg;
    assign s_addr    = addr_reg;
    assign s_wdata   = wdata_reg;
    assign s_be      = be_reg;
    assign cpu_ack   = (state_reg == DONE);
    assign cpu_err   = (state_reg == DONE) && err_reg;
    assign cpu_rdata = rdata_reg;
    assign cpu_busy  = (state_reg != IDLE);
endmodule

// File: tb/tb_dbus_demux.sv
// Bench for dbus_demux: directed + random requests, slave responders, scoreboard monitor.
`timescale 1ns/1ps
module tb_dbus_demux;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack, cpu_err, cpu_busy;
    logic [31:0] cpu_rdata;
    logic        s0_stb, s1_stb, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s0_ack = 1'b0, s1_ack = 1'b0;
    logic [31:0] s0_rdata = '0, s1_rdata = '0;

    dbus_demux dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .cpu_busy(cpu_busy), .s0_stb(s0_stb), .s1_stb(s1_stb),
        .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s0_ack(s0_ack), .s1_ack(s1_ack), .s0_rdata(s0_rdata), .s1_rdata(s1_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stbcnt;
        int          slave;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cur_delay = 0;
    logic [31:0] cur_data = '0;
    logic [31:0] last_rdata = '0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Reference model: completion derived directly from the address map and slave latency
    function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] be, input int delay, input logic [31:0] sdata);
        exp_t e;
        longint a = longint'(addr);
        e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
        if (a < 64'h3000) e.slave = 0;
        else if (a >= 64'h7F00 && a < 64'h7F00 + 64'h100) e.slave = 1;
        else e.slave = -1;
        if (e.slave < 0) begin
            e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.stbcnt = 0;
        end else if (delay < 16) begin
            e.err = 1'b0; e.rdata = we ? 32'h0 : sdata; e.stbcnt = delay + 1;
        end else begin
            e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.stbcnt = 16;
        end
        return e;
    endfunction

    // Slave responders: active slave acks after cur_delay strobed cycles; the other slave babbles
    initial begin
        int bcnt = 0;
        forever begin
            @(negedge clk);
            s0_ack = 1'b0; s1_ack = 1'b0;
            s0_rdata = $urandom; s1_rdata = $urandom;
            if (s0_stb || s1_stb) begin
                if (s0_stb) s1_ack = 1'($urandom % 2);
                else        s0_ack = 1'($urandom % 2);
                if (bcnt == cur_delay) begin
                    if (s0_stb) begin s0_ack = 1'b1; s0_rdata = cur_data; end
                    else        begin s1_ack = 1'b1; s1_rdata = cur_data; end
                end
                bcnt++;
            end else begin
                bcnt = 0;
            end
        end
    end

    // Monitor: tracks strobes/fields per transfer and scores each cpu_ack against the queue
    initial begin
        int   stb_cnt = 0;
        bit   fields_ok = 1;
        logic prev_ack = 1'b0;
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (prev_ack) begin
                check("idle_after_ack", {29'h0, cpu_busy, s0_stb, s1_stb}, 32'h0);
                check("rdata_hold", cpu_rdata, last_rdata);
            end
            prev_ack = cpu_ack;
            if (!cpu_busy) begin stb_cnt = 0; fields_ok = 1; end
            if (s0_stb || s1_stb) begin
                stb_cnt++;
                if (q.size() == 0) fields_ok = 0;
                else begin
                    e = q[0];
                    if ((s0_stb && s1_stb) || ((s1_stb ? 1 : 0) != e.slave) || s_we !== e.we ||
                        s_addr !== e.addr || s_wdata !== e.wdata || s_be !== e.be)
                        fields_ok = 0;
                end
            end
            if (cpu_ack) begin
                if (q.size() == 0) check("spurious_ack", 32'h1, 32'h0);
                else begin
                    e = q.pop_front();
                    check("rdata", cpu_rdata, e.rdata);
                    check("err", {31'h0, cpu_err}, {31'h0, e.err});
                    check("stb_cycles", stb_cnt, e.stbcnt);
                    check("s_fields_stable", {31'h0, fields_ok}, 32'h1);
                    last_rdata = e.rdata;
                end
            end
        end
    end

    // Presents one request in IDLE, then waits (bounded) for the return to IDLE
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int delay, input logic [31:0] sdata, input bit hold);
        int n = 0;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be; cpu_req = 1'b1;
        cur_delay = delay; cur_data = sdata;
        q.push_back(model(we, addr, wdata, be, delay, sdata));
        $display("txn we=%0d addr=0x%08h wdata=0x%08h be=%b delay=%0d hold=%0d",
                 we, addr, wdata, be, delay, hold);
        @(negedge clk);
        if (!hold) cpu_req = 1'b0;
        while (cpu_busy && n < 60) begin @(negedge clk); n++; end
        check("return_idle", {31'h0, cpu_busy}, 32'h0);
    endtask

    logic [31:0] bnd [8] = '{32'h0000_0000, 32'h0000_2FFC, 32'h0000_3000, 32'h0000_7EFC,
                             32'h0000_7F00, 32'h0000_7FFC, 32'h0000_8000, 32'hFFFF_FFFC};
    int dly [10] = '{0, 1, 2, 3, 5, 14, 15, 16, 40, 100};

    initial begin
        logic [31:0] a;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'h0, cpu_ack, cpu_busy, s0_stb, s1_stb}, 32'h0);
        check("rst_rdata_err", cpu_rdata | {31'h0, cpu_err}, 32'h0);
        check("rst_fields", s_addr | s_wdata | {27'h0, s_we, s_be}, 32'h0);
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);

        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0);
        issue(1'b1, 32'h0000_7F04, 32'hA5A5_0000, 4'b1100, 2, 32'h0BAD_0BAD, 1'b0);
        issue(1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, 32'h1111_1111, 1'b0);
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF, 100, 32'h2222_2222, 1'b0);
        issue(1'b0, 32'h0000_0104, 32'h0, 4'hF, 15, 32'h3333_3333, 1'b0);

        // Reset during the second BUSY cycle aborts the transfer without an ack
        cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = '0; cpu_be = 4'hF; cpu_req = 1'b1;
        cur_delay = 100;
        q.push_back(model(1'b0, 32'h20, 32'h0, 4'hF, 100, 32'h0));
        $display("txn reset-abort addr=0x00000020");
        @(negedge clk); cpu_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {28'h0, cpu_ack, cpu_busy, s0_stb, s1_stb}, 32'h0);
        check("abort_fields", s_addr, 32'h0);
        q.delete();
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h0000_2FFC, 32'h0, 4'hF, 1, 32'h4444_4444, 1'b0);

        // Back-to-back requests with cpu_req held high
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, 3, 32'h5555_5555, 1'b1);
        issue(1'b1, 32'h0000_7F00, 32'h6666_6666, 4'h3, 0, 32'h7777_7777, 1'b1);
        issue(1'b0, 32'h0000_8000, 32'h0, 4'hF, 0, 32'h8888_8888, 1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 32'h2FFF);
                1: a = 32'h7F00 + $urandom_range(0, 32'hFF);
                2: a = $urandom;
                default: a = bnd[$urandom_range(0, 7)];
            endcase
            issue(1'($urandom % 2), a, $urandom, 4'($urandom), dly[$urandom_range(0, 9)],
                  $urandom, 1'($urandom % 2));
        end
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
